// File: rtl/load_store_unit.sv
// Memory-access stage: drives a req/gnt/rvalid data port, builds byte enables and
// replicated store data, and extends load data. Optional feature macro: MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [2:0]              Funct3,
  input  logic [DATA_WIDTH-1:0]   ALUResult,
  input  logic [DATA_WIDTH-1:0]   StoreData,
  output logic                    busy,
  output logic                    lsu_done,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic                    misalign,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] wb_q, wb_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [2:0]            f3_q, f3_d;
  logic                  we_q, we_d;
  logic                  misal_q, misal_d;

  logic                  accept_c;
  logic                  misal_c;
  logic [BE_W-1:0]       be_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] ld_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;

  // Funct3[1:0]: 00 byte, 01 half, 1x word (covers 011/110/111 as word)
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = StoreData;
    case (Funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ALUResult[1:0];
        wdata_c = {4{StoreData[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {ALUResult[1], 1'b0};
        wdata_c = {2{StoreData[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misal_c = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                   (Funct3[1] && (ALUResult[1:0] != 2'b00));
`else
  assign misal_c = 1'b0;
`endif

  // Lane select and extension of returning load data
  always_comb begin
    byte_c = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
    half_c = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_c = f3_q[2] ? {24'b0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   ld_c = f3_q[2] ? {16'b0, half_c} : {{16{half_c[15]}}, half_c};
      default: ld_c = mem_rdata;
    endcase
  end

  assign ex_ready = (state_q == S_IDLE) || (state_q == S_RESP);
  assign accept_c = ex_ready && ex_valid && (MemRead || MemWrite);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wb_d    = wb_q;
    be_d    = be_q;
    f3_d    = f3_q;
    we_d    = we_q;
    misal_d = misal_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (state_q == S_RESP) state_d = S_IDLE;
        if (accept_c) begin
          addr_d  = ALUResult;
          wdata_d = wdata_c;
          be_d    = be_c;
          f3_d    = Funct3;
          we_d    = MemWrite && !MemRead;
          wb_d    = '0;
          misal_d = misal_c;
          state_d = misal_c ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = we_q ? S_RESP : S_WAIT_R;
      end
      S_WAIT_R: begin
        if (mem_rvalid) begin
          wb_d    = ld_c;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wb_q    <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wb_q    <= wb_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      misal_q <= misal_d;
    end
  end

  // Port outputs decode straight from state so reset clears them at once
  assign busy      = (state_q == S_REQ) || (state_q == S_WAIT_R);
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be_q : '0;
  assign mem_wdata = (mem_req && we_q) ? wdata_q : '0;
  assign lsu_done  = (state_q == S_RESP);
  assign wb_data   = lsu_done ? wb_q : '0;
  assign misalign  = lsu_done && misal_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult;
  logic [31:0] StoreData;
  logic        busy;
  logic        lsu_done;
  logic [31:0] wb_data;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int vectors;
  int miscompares;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .StoreData(StoreData), .busy(busy),
    .lsu_done(lsu_done), .wb_data(wb_data), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one access for a single cycle; returns in the first REQ (or RESP) cycle
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3;
    ALUResult = a; StoreData = d;
    step();
    ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // Zero-wait load: gnt with req, rvalid in the following cycle
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [31:0] exp);
    mem_gnt = 1'b1;
    issue(1'b1, 1'b0, f3, a, 32'h0);
    chkb({tag, "_req"}, mem_req, 1'b1);
    chkb({tag, "_we"}, mem_we, 1'b0);
    step();
    mem_rvalid = 1'b1; mem_rdata = rdata;
    chkb({tag, "_wait_done"}, lsu_done, 1'b0);
    step();
    mem_rvalid = 1'b0;
    chkb({tag, "_done"}, lsu_done, 1'b1);
    chk({tag, "_wb"}, wb_data, exp);
    step();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Funct3 = 3'b000; ALUResult = 32'h0; StoreData = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    #12;
    chkb("rst_ex_ready", ex_ready, 1'b1);
    chkb("rst_req", mem_req, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", lsu_done, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // ex_valid without a memory op is ignored
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    chkb("noop_req", mem_req, 1'b0);
    chkb("noop_busy", busy, 1'b0);

    // SW, immediate grant: req at T+1, done at T+2
    mem_gnt = 1'b1;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    chkb("sw_req", mem_req, 1'b1);
    chkb("sw_we", mem_we, 1'b1);
    chk("sw_addr", mem_addr, 32'h0000_0100);
    chk("sw_be", 32'(mem_be), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chkb("sw_busy", busy, 1'b1);
    chkb("sw_ex_ready", ex_ready, 1'b0);
    chkb("sw_early_done", lsu_done, 1'b0);
    step();
    chkb("sw_done", lsu_done, 1'b1);
    chk("sw_wb", wb_data, 32'h0);
    chkb("sw_busy_resp", busy, 1'b0);
    step();
    chkb("sw_done_pulse", lsu_done, 1'b0);

    // SB to lane 3, then back-to-back SH accepted during RESP
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
    chk("sb_addr", mem_addr, 32'h0000_0100);
    chk("sb_be", 32'(mem_be), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    step();
    chkb("sb_done", lsu_done, 1'b1);
    chkb("sb_ex_ready", ex_ready, 1'b1);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF);
    chkb("sh_req", mem_req, 1'b1);
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    step();
    chkb("sh_done", lsu_done, 1'b1);
    step();

    // Loads from rdata 0x12F45678
    do_load("lb",  3'b000, 32'h0000_0102, 32'h12F4_5678, 32'hFFFF_FFF4);
    do_load("lbu", 3'b100, 32'h0000_0102, 32'h12F4_5678, 32'h0000_00F4);
    do_load("lhu", 3'b101, 32'h0000_0102, 32'h12F4_5678, 32'h0000_12F4);
    do_load("lb1", 3'b000, 32'h0000_0101, 32'h12F4_5678, 32'h0000_0056);
    do_load("lh0", 3'b001, 32'h0000_0100, 32'h8765_9ABC, 32'hFFFF_9ABC);
    do_load("lw",  3'b010, 32'h0000_0104, 32'h12F4_5678, 32'h12F4_5678);
    do_load("f3w", 3'b110, 32'h0000_0108, 32'h8000_0001, 32'h8000_0001);

    // MemRead & MemWrite together is a load
    mem_gnt = 1'b1;
    issue(1'b1, 1'b1, 3'b010, 32'h0000_0200, 32'h5555_5555);
    chkb("rw_we", mem_we, 1'b0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_rvalid = 1'b0;
    chk("rw_wb", wb_data, 32'h0BAD_F00D);
    step();

    // Grant withheld: port held stable, rvalid in REQ ignored
    mem_gnt = 1'b0;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h1122_3344);
    mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chkb("stall_req", mem_req, 1'b1);
      chk("stall_addr", mem_addr, 32'h0000_0200);
      chk("stall_be", 32'(mem_be), 32'hF);
      chk("stall_wdata", mem_wdata, 32'h1122_3344);
      chkb("stall_busy", busy, 1'b1);
      chkb("stall_ex_ready", ex_ready, 1'b0);
      chkb("stall_done", lsu_done, 1'b0);
      step();
    end
    mem_rvalid = 1'b0;
    mem_gnt = 1'b1;
    chkb("stall_req_last", mem_req, 1'b1);
    step();
    chkb("stall_gnt_done", lsu_done, 1'b1);
    step();

    // Reset during WAIT_R aborts at once; later rvalid ignored
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
    step();
    chkb("abort_busy_pre", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chkb("abort_busy", busy, 1'b0);
    chkb("abort_req", mem_req, 1'b0);
    chkb("abort_ex_ready", ex_ready, 1'b1);
    #2 reset = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    chkb("abort_no_done0", lsu_done, 1'b0);
    step();
    chkb("abort_no_done1", lsu_done, 1'b0);
    mem_rvalid = 1'b0;
    step();

    // Misaligned LW
    mem_gnt = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chkb("mis_req", mem_req, 1'b0);
    chkb("mis_done", lsu_done, 1'b1);
    chkb("mis_flag", misalign, 1'b1);
    chk("mis_wb", wb_data, 32'h0);
    step();
    chkb("mis_done_pulse", lsu_done, 1'b0);
`else
    chkb("mis_req", mem_req, 1'b1);
    chk("mis_addr", mem_addr, 32'h0000_0100);
    chk("mis_be", 32'(mem_be), 32'hF);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    chkb("mis_done", lsu_done, 1'b1);
    chkb("mis_flag", misalign, 1'b0);
    chk("mis_wb", wb_data, 32'hCAFE_F00D);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
